// File: rtl/irq_timer_source.sv
// irq_timer_source: three programmable countdown timers driving the CPU
// interrupt_signs lines, with level IRQs cleared by int_ack or W1C.
module irq_timer_source #(
   parameter int CHANNELS = 3,
   parameter int WIDTH    = 32
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                we,
   input  logic [3:0]          addr,
   input  logic [31:0]         wdata,
   output logic [31:0]         rdata,
   input  logic [CHANNELS-1:0] int_ack,
   output logic [CHANNELS-1:0] interrupt_signs
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      FIRED = 2'd2
   } state_e;

   state_e             st_q    [CHANNELS];
   logic [WIDTH-1:0]   load_q  [CHANNELS];
   logic [WIDTH-1:0]   count_q [CHANNELS];
   logic [2:0]         ctrl_q  [CHANNELS];
   logic [CHANNELS-1:0] pend_q, pend_d;
   logic [CHANNELS-1:0] ovr_q, ovr_d;

   logic [CHANNELS-1:0] wr_load;
   logic [CHANNELS-1:0] wr_ctrl;
   logic [CHANNELS-1:0] wr_stat;
   logic [CHANNELS-1:0] fire;
   logic [CHANNELS-1:0] clr_pend;

   always_comb begin
      wr_load  = '0;
      wr_ctrl  = '0;
      wr_stat  = '0;
      fire     = '0;
      clr_pend = '0;
      pend_d   = '0;
      ovr_d    = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         if (we && addr[3:2] == 2'(i)) begin
            wr_load[i] = (addr[1:0] == 2'd0);
            wr_ctrl[i] = (addr[1:0] == 2'd1);
            wr_stat[i] = (addr[1:0] == 2'd3);
         end
         fire[i]     = (st_q[i] == RUN) && (count_q[i] == '0);
         clr_pend[i] = int_ack[i] | (wr_stat[i] & wdata[0]);
         // a fire in the same cycle as a clear wins and is not an overrun
         pend_d[i]   = fire[i] | (pend_q[i] & ~clr_pend[i]);
         ovr_d[i]    = (fire[i] & pend_q[i] & ~clr_pend[i])
                     | (ovr_q[i] & ~(wr_stat[i] & wdata[1]));
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend_q <= '0;
         ovr_q  <= '0;
         for (int i = 0; i < CHANNELS; i++) begin
            st_q[i]    <= IDLE;
            load_q[i]  <= '0;
            count_q[i] <= '0;
            ctrl_q[i]  <= '0;
         end
      end else begin
         pend_q <= pend_d;
         ovr_q  <= ovr_d;
         for (int i = 0; i < CHANNELS; i++) begin
            if (wr_load[i])
               load_q[i] <= wdata[WIDTH-1:0];
            if (wr_ctrl[i]) begin
               ctrl_q[i] <= wdata[2:0];
               if (wdata[0]) begin
                  count_q[i] <= load_q[i];
                  st_q[i]    <= RUN;
               end else begin
                  st_q[i]    <= IDLE;
               end
            end else if (st_q[i] == RUN) begin
               if (count_q[i] != '0)
                  count_q[i] <= count_q[i] - WIDTH'(1);
               else if (ctrl_q[i][1])
                  count_q[i] <= load_q[i];
               else
                  st_q[i]    <= FIRED;
            end
         end
      end
   end

   always_comb begin
      rdata = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         if (addr[3:2] == 2'(i)) begin
            case (addr[1:0])
               2'd0:    rdata = 32'(load_q[i]);
               2'd1:    rdata = {29'd0, ctrl_q[i]};
               2'd2:    rdata = 32'(count_q[i]);
               default: rdata = {30'd0, ovr_q[i], pend_q[i]};
            endcase
         end
      end
   end

   always_comb begin
      interrupt_signs = '0;
      for (int i = 0; i < CHANNELS; i++)
         interrupt_signs[i] = pend_q[i] & ctrl_q[i][2];
   end

endmodule

// File: tb/tb_irq_timer_source.sv
// Directed bench for irq_timer_source: expected values queued per step,
// popped and asserted when the DUT output is sampled.
module tb_irq_timer_source;

   logic        clk;
   logic        rst_n;
   logic        we;
   logic [3:0]  addr;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic [2:0]  int_ack;
   logic [2:0]  interrupt_signs;

   typedef struct {
      string       tag;
      logic [31:0] exp;
   } sb_t;

   sb_t sb[$];
   int  ntests = 0;
   int  nfail  = 0;

   irq_timer_source #(.CHANNELS(3), .WIDTH(32)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .we              (we),
      .addr            (addr),
      .wdata           (wdata),
      .rdata           (rdata),
      .int_ack         (int_ack),
      .interrupt_signs (interrupt_signs)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic push(input string tag, input logic [31:0] v);
      sb_t e;
      e.tag = tag;
      e.exp = v;
      sb.push_back(e);
   endtask

   task automatic cmp(input logic [31:0] obs);
      sb_t e;
      e = sb.pop_front();
      ntests++;
      assert (obs === e.exp) else begin
         nfail++;
         $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [3:0] a, input logic [31:0] d);
      we    = 1'b1;
      addr  = a;
      wdata = d;
      @(posedge clk);
      #1;
      we    = 1'b0;
      wdata = '0;
   endtask

   task automatic chk_rd(input string tag, input logic [3:0] a,
                         input logic [31:0] v);
      push(tag, v);
      addr = a;
      #1;
      cmp(rdata);
   endtask

   task automatic chk_sig(input string tag, input logic [2:0] v);
      push(tag, {29'd0, v});
      cmp({29'd0, interrupt_signs});
   endtask

   initial begin
      rst_n   = 1'b0;
      we      = 1'b0;
      addr    = '0;
      wdata   = '0;
      int_ack = '0;
      #2;
      chk_sig("rst_sig", 3'b000);
      chk_rd("rst_load0", 4'h0, 32'd0);
      chk_rd("rst_ctrl0", 4'h1, 32'd0);
      chk_rd("rst_stat0", 4'h3, 32'd0);
      #10 rst_n = 1'b1;
      cyc(1);

      // one-shot on ch0
      wr(4'h0, 32'd3);
      wr(4'h1, 32'b101);
      cyc(3);
      chk_sig("os_pre", 3'b000);
      cyc(1);
      chk_sig("os_fire", 3'b001);
      chk_rd("os_count", 4'h2, 32'd0);
      chk_rd("os_stat", 4'h3, 32'd1);
      cyc(3);
      chk_sig("os_hold", 3'b001);
      int_ack = 3'b001;
      cyc(1);
      int_ack = 3'b000;
      chk_sig("os_ack", 3'b000);
      cyc(6);
      chk_sig("os_nofire", 3'b000);
      chk_rd("os_stat2", 4'h3, 32'd0);

      // periodic and overrun on ch1
      wr(4'h4, 32'd2);
      wr(4'h5, 32'b111);
      cyc(2);
      chk_sig("per_pre", 3'b000);
      cyc(1);
      chk_sig("per_f1", 3'b010);
      chk_rd("per_st1", 4'h7, 32'd1);
      cyc(3);
      chk_rd("per_ovr", 4'h7, 32'd3);
      wr(4'h7, 32'd3);
      chk_rd("per_w1c", 4'h7, 32'd0);
      chk_sig("per_w1c_sig", 3'b000);
      cyc(2);
      chk_rd("per_f3", 4'h7, 32'd1);
      chk_sig("per_f3_sig", 3'b010);
      wr(4'h5, 32'd0);
      chk_rd("dis_cnt", 4'h6, 32'd2);
      cyc(5);
      chk_rd("dis_frz", 4'h6, 32'd2);
      chk_rd("dis_stat", 4'h7, 32'd1);
      int_ack = 3'b010;
      cyc(1);
      int_ack = 3'b000;
      chk_sig("dis_ack", 3'b000);

      // ack collision on ch2
      wr(4'h8, 32'd0);
      wr(4'h9, 32'b111);
      int_ack = 3'b100;
      cyc(1);
      chk_sig("col_f", 3'b100);
      cyc(4);
      chk_sig("col_hold", 3'b100);
      chk_rd("col_stat", 4'hB, 32'd1);
      wr(4'h9, 32'd0);
      cyc(1);
      chk_sig("col_off", 3'b000);
      chk_rd("col_stat2", 4'hB, 32'd0);
      int_ack = 3'b000;

      // irq_en gating and LOAD update on ch0
      wr(4'h0, 32'd4);
      wr(4'h1, 32'b011);
      cyc(1);
      wr(4'h0, 32'd7);
      cyc(2);
      chk_rd("gate_pre", 4'h3, 32'd0);
      cyc(1);
      chk_rd("gate_pend", 4'h3, 32'd1);
      chk_sig("gate_sig", 3'b000);
      wr(4'h3, 32'd1);
      chk_rd("gate_w1c", 4'h3, 32'd0);
      cyc(6);
      chk_rd("ld_cnt", 4'h2, 32'd0);
      chk_rd("ld_pre", 4'h3, 32'd0);
      cyc(1);
      chk_rd("ld_fire", 4'h3, 32'd1);
      chk_rd("ld_reload", 4'h2, 32'd7);
      wr(4'h1, 32'd0);
      wr(4'h3, 32'd1);

      // register access and unmapped channel
      wr(4'hC, 32'hDEAD_BEEF);
      wr(4'hD, 32'd5);
      chk_rd("unm_c", 4'hC, 32'd0);
      chk_rd("unm_d", 4'hD, 32'd0);
      wr(4'h4, 32'h1234_5678);
      chk_rd("ld_rw", 4'h4, 32'h1234_5678);
      wr(4'h6, 32'd9);
      chk_rd("cnt_ro", 4'h6, 32'd2);
      wr(4'h5, 32'hFFFF_FFF8);
      chk_rd("ctrl_mask", 4'h5, 32'd0);
      cyc(3);
      chk_sig("quiet", 3'b000);

      // asynchronous reset mid-count
      wr(4'h4, 32'd5);
      wr(4'h5, 32'b111);
      cyc(2);
      chk_rd("mid_cnt", 4'h6, 32'd3);
      #2 rst_n = 1'b0;
      #1;
      chk_sig("ar_sig", 3'b000);
      chk_rd("ar_cnt", 4'h6, 32'd0);
      chk_rd("ar_stat", 4'h7, 32'd0);
      chk_rd("ar_load", 4'h4, 32'd0);
      #3 rst_n = 1'b1;
      for (int k = 0; k < 20; k++) begin
         cyc(1);
         chk_sig("ar_quiet", 3'b000);
      end
      chk_rd("ar_stat2", 4'h7, 32'd0);

      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end

endmodule
